eeprom_burst_seq: RTL and testbench

//  Parametrised command-to-byte sequencer between the UART command decoder and the I2C register master.

---
 rtl/eeprom_seq_pkg.sv | 22 ++
 rtl/eeprom_byte_lane.sv | 47 ++++
 rtl/eeprom_burst_seq.sv | 165 ++++++++++++++++
 tb/tb_eeprom_burst_seq.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_seq_pkg.sv
// Shared types for the EEPROM burst sequencer.
// State encoding, error codes and payload byte-lane mapping.
package eeprom_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;

    // Byte 0 sits in the most significant lane of the payload.
    function automatic int lane_lsb(input int idx, input int max_bytes);
        return 8 * (max_bytes - 1 - idx);
    endfunction

endpackage

// File: rtl/eeprom_byte_lane.sv
// Payload byte select and read-data byte insert.
// Lane 0 is the most significant byte of both buses.
module eeprom_byte_lane
    import eeprom_seq_pkg::*;
#(
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1),
    parameter int DATA_W    = 8 * MAX_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] payload,
    input  logic [LEN_W-1:0]  sel_idx,
    output logic [7:0]        sel_byte,
    input  logic              clear,
    input  logic              ins_en,
    input  logic [LEN_W-1:0]  ins_idx,
    input  logic [7:0]        ins_byte,
    output logic [DATA_W-1:0] rd_data
);

    // Pick the payload byte for the requested index; out-of-range gives 0.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (sel_idx == LEN_W'(i)) begin
                sel_byte = payload[lane_lsb(i, MAX_BYTES) +: 8];
            end
        end
    end

    // Read payload: cleared on a read accept, one byte written per good read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clear) begin
            rd_data <= '0;
        end else if (ins_en) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (ins_idx == LEN_W'(i)) begin
                    rd_data[lane_lsb(i, MAX_BYTES) +: 8] <= ins_byte;
                end
            end
        end
    end

endmodule

// File: rtl/eeprom_burst_seq.sv
// Burst command to single-byte I2C register transaction sequencer.
// Handles NACK retry, length checks and completion pulses.
module eeprom_burst_seq
    import eeprom_seq_pkg::*;
#(
    parameter int MAX_BYTES = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8 * MAX_BYTES,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1),
    parameter int RETRY_MAX = 3
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              wr_req,
    output logic              rd_req,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        wr_byte,
    input  logic [7:0]        rd_byte,
    input  logic              rw_done,
    input  logic              ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [LEN_W-1:0]  err_idx
);

    localparam int TRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_t              state;
    logic                rd_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [LEN_W-1:0]    idx;
    logic [TRY_W-1:0]    tries;
    logic [LEN_W-1:0]    lane_idx;
    logic [7:0]          sel_byte;
    logic                len_ok;
    logic                last;
    logic                retry;
    logic                go_issue;

    // Next byte index and whether the next cycle issues a request.
    always_comb begin
        lane_idx = idx + LEN_W'(1);
        if (state == CHECK) begin
            lane_idx = '0;
        end else if (ack) begin
            lane_idx = idx;
        end
        len_ok   = (len_q != '0) && (len_q <= LEN_W'(MAX_BYTES));
        last     = (idx == len_q - LEN_W'(1));
        retry    = (tries < TRY_W'(RETRY_MAX));
        go_issue = ((state == CHECK) && len_ok) ||
                   ((state == WAIT) && rw_done && (ack ? retry : !last));
    end

    eeprom_byte_lane #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W)
    ) u_lane (
        .clk      (clk50M),
        .rst      (rst),
        .payload  (data_q),
        .sel_idx  (lane_idx),
        .sel_byte (sel_byte),
        .clear    ((state == IDLE) && cmd_valid && cmd_ready && cmd_rd),
        .ins_en   ((state == WAIT) && rw_done && !ack && rd_q),
        .ins_idx  (idx),
        .ins_byte (rd_byte),
        .rd_data  (rd_data)
    );

    // Sequencer FSM with registered handshake, request and status outputs.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rd_q      <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            idx       <= '0;
            tries     <= '0;
            wr_req    <= 1'b0;
            rd_req    <= 1'b0;
            reg_addr  <= '0;
            wr_byte   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
        end else begin
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_q      <= cmd_rd;
                        len_q     <= cmd_len;
                        addr_q    <= cmd_addr;
                        data_q    <= cmd_data;
                        err_code  <= ERR_NONE;
                        err_idx   <= '0;
                        cmd_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (len_q == '0) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (!len_ok) begin
                        err      <= 1'b1;
                        err_code <= ERR_LEN;
                        err_idx  <= '0;
                        state    <= FINISH;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rw_done && !ack && last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (rw_done && ack && !retry) begin
                        err      <= 1'b1;
                        err_code <= ERR_NACK;
                        err_idx  <= idx;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
            if (go_issue) begin
                wr_req   <= !rd_q;
                rd_req   <= rd_q;
                idx      <= lane_idx;
                tries    <= ((state == WAIT) && ack) ? tries + TRY_W'(1) : '0;
                reg_addr <= addr_q + ADDR_W'(lane_idx);
                wr_byte  <= sel_byte;
                state    <= ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_eeprom_burst_seq.sv
// Randomized bench for eeprom_burst_seq against a burst-level reference model.
// Each scenario task drives one feature and checks its own results.
module tb_eeprom_burst_seq;

    localparam int MB    = 16;
    localparam int RETRY = 3;

    logic         clk50M = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_rd = 1'b0;
    logic [4:0]   cmd_len = '0;
    logic [15:0]  cmd_addr = '0;
    logic [127:0] cmd_data = '0;
    logic         wr_req;
    logic         rd_req;
    logic [15:0]  reg_addr;
    logic [7:0]   wr_byte;
    logic [7:0]   rd_byte = '0;
    logic         rw_done = 1'b0;
    logic         ack = 1'b0;
    logic [127:0] rd_data;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic [4:0]   err_idx;

    int checks = 0;
    int errors = 0;

    int          nack_plan[32];
    logic [7:0]  rd_vals[32];
    int          fails_seen[32];
    logic [15:0] obs_addr[$];
    logic [7:0]  obs_byte[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_byte[$];

    bit  got_done, got_err, post_ready, post_pulse, timeout;
    int  first_lat, pulse_cyc, late, extra, ready_bad, wrong_dir;
    int  both_hi = 0;

    logic [127:0] m_rd = '0;
    logic [1:0]   m_code = '0;
    int           m_idx = 0;
    bit           exp_done, exp_err;

    eeprom_burst_seq dut (
        .clk50M    (clk50M),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_len   (cmd_len),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .reg_addr  (reg_addr),
        .wr_byte   (wr_byte),
        .rd_byte   (rd_byte),
        .rw_done   (rw_done),
        .ack       (ack),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .err_idx   (err_idx)
    );

    always #10 clk50M = ~clk50M;

    always @(posedge clk50M) begin
        if (wr_req && rd_req) both_hi++;
    end

    task automatic clear_plan;
        for (int i = 0; i < 32; i++) begin
            nack_plan[i] = 0;
            rd_vals[i]   = 8'($urandom);
        end
    endtask

    // Reference: expected request list and final status of one burst.
    task automatic model_burst(input bit rd, input int len,
                               input logic [15:0] a, input logic [127:0] d);
        int n;
        exp_addr.delete();
        exp_byte.delete();
        m_code   = 2'd0;
        m_idx    = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rd) m_rd = '0;
        if (len == 0) begin
            exp_done = 1'b1;
        end else if (len > MB) begin
            exp_err = 1'b1;
            m_code  = 2'd2;
        end else begin
            exp_done = 1'b1;
            for (int i = 0; i < len; i++) begin
                n = (nack_plan[i] > RETRY) ? RETRY + 1 : nack_plan[i] + 1;
                for (int t = 0; t < n; t++) begin
                    exp_addr.push_back(a + 16'(i));
                    exp_byte.push_back(d[127 - 8*i -: 8]);
                end
                if (nack_plan[i] > RETRY) begin
                    exp_done = 1'b0;
                    exp_err  = 1'b1;
                    m_code   = 2'd1;
                    m_idx    = i;
                    break;
                end
                if (rd) m_rd[127 - 8*i -: 8] = rd_vals[i];
            end
        end
    endtask

    // Issue one command and play the I2C master until done/err.
    task automatic drive_burst(input bit rd, input int len,
                               input logic [15:0] a, input logic [127:0] d,
                               input bit hold);
        int cyc;
        int bi;
        bit fin;
        bit after;
        obs_addr.delete();
        obs_byte.delete();
        for (int i = 0; i < 32; i++) fails_seen[i] = 0;
        got_done = 0; got_err = 0; timeout = 0;
        first_lat = -1; pulse_cyc = -1;
        late = 0; extra = 0; ready_bad = 0; wrong_dir = 0;
        post_ready = 0; post_pulse = 0;
        @(negedge clk50M);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_len   = 5'(len);
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk50M);
        if (!hold) cmd_valid = 1'b0;
        cmd_rd   = 1'($urandom);
        cmd_len  = 5'($urandom);
        cmd_addr = 16'($urandom);
        cmd_data = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1; fin = 0; after = 0;
        while (!fin) begin
            if (cyc > 600) begin
                timeout = 1;
                cmd_valid = 1'b0;
                break;
            end
            if (cmd_ready) ready_bad++;
            if (after && !(wr_req || rd_req || done || err)) late++;
            after = 0;
            if (wr_req || rd_req) begin
                if (first_lat < 0) first_lat = cyc;
                if (rd_req !== rd || wr_req === rd) wrong_dir++;
                obs_addr.push_back(reg_addr);
                obs_byte.push_back(wr_byte);
                bi = int'(16'(reg_addr - a));
                if (bi > 31) bi = 31;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk50M);
                    cyc++;
                    if (wr_req || rd_req || done || err) extra++;
                end
                rw_done = 1'b1;
                ack     = (fails_seen[bi] < nack_plan[bi]);
                if (ack) fails_seen[bi]++;
                rd_byte = rd_vals[bi];
                @(negedge clk50M);
                cyc++;
                rw_done = 1'b0;
                ack     = 1'($urandom);
                rd_byte = 8'($urandom);
                after   = 1;
            end else if (done || err) begin
                got_done  = done;
                got_err   = err;
                pulse_cyc = cyc;
                fin       = 1;
                if (hold) cmd_valid = 1'b0;
                @(negedge clk50M);
                post_ready = cmd_ready;
                post_pulse = done | err;
            end else begin
                @(negedge clk50M);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk50M);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        checks++;
        if ({wr_req, rd_req, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0000",
                     {wr_req, rd_req, done, err});
        end
        checks++;
        if (rd_data !== '0 || reg_addr !== '0 || wr_byte !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", rd_data, reg_addr, wr_byte);
        end
        checks++;
        if (err_code !== 2'd0 || err_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_err got %0d/%0d want 0/0", err_code, err_idx);
        end
        rst = 1'b0;
        m_rd = '0;
    endtask

    task automatic test_write_wrap;
        logic [127:0] d;
        clear_plan();
        d = {32'hA1B2C3D4, $urandom, $urandom, $urandom};
        model_burst(0, 4, 16'hFFFE, d);
        drive_burst(0, 4, 16'hFFFE, d, 0);
        checks++;
        if (obs_addr.size() !== 4 || timeout) begin
            errors++;
            $display("FAIL wr_count got %0d want 4 (timeout %0d)", obs_addr.size(), timeout);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_byte[i] !== exp_byte[i]) begin
                errors++;
                $display("FAIL wr_req%0d got %h:%h want %h:%h", i,
                         obs_addr[i], obs_byte[i], exp_addr[i], exp_byte[i]);
            end
        end
        checks++;
        if (!got_done || got_err || err_code !== 2'd0 || first_lat !== 2) begin
            errors++;
            $display("FAIL wr_status got done%0d err%0d code%0d lat%0d want 1 0 0 2",
                     got_done, got_err, err_code, first_lat);
        end
        checks++;
        if (late !== 0 || extra !== 0 || wrong_dir !== 0 || ready_bad !== 0) begin
            errors++;
            $display("FAIL wr_timing got late%0d extra%0d dir%0d rdy%0d want 0",
                     late, extra, wrong_dir, ready_bad);
        end
    endtask

    task automatic test_read_full;
        logic [127:0] want;
        want = 128'h101112131415161718191A1B1C1D1E1F;
        clear_plan();
        for (int i = 0; i < MB; i++) rd_vals[i] = 8'(i + 16);
        model_burst(1, MB, 16'h0000, '0);
        drive_burst(1, MB, 16'h0000, '0, 0);
        checks++;
        if (rd_data !== want || rd_data !== m_rd) begin
            errors++;
            $display("FAIL rd_full_data got %h want %h", rd_data, want);
        end
        checks++;
        if (obs_addr.size() !== MB || wrong_dir !== 0) begin
            errors++;
            $display("FAIL rd_full_count got %0d dir%0d want %0d", obs_addr.size(), wrong_dir, MB);
        end
        checks++;
        if (!got_done || late !== 0 || !post_ready || post_pulse) begin
            errors++;
            $display("FAIL rd_full_done got done%0d late%0d rdy%0d pulse%0d want 1 0 1 0",
                     got_done, late, post_ready, post_pulse);
        end
    endtask

    task automatic test_retry;
        logic [127:0] d;
        clear_plan();
        nack_plan[1] = 2;
        d = {$urandom, $urandom, $urandom, $urandom};
        model_burst(0, 3, 16'h1234, d);
        drive_burst(0, 3, 16'h1234, d, 0);
        checks++;
        if (obs_addr.size() !== 5) begin
            errors++;
            $display("FAIL retry_count got %0d want 5", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_byte[i] !== exp_byte[i]) begin
                errors++;
                $display("FAIL retry_req%0d got %h:%h want %h:%h", i,
                         obs_addr[i], obs_byte[i], exp_addr[i], exp_byte[i]);
            end
        end
        checks++;
        if (!got_done || got_err || late !== 0) begin
            errors++;
            $display("FAIL retry_status got done%0d err%0d late%0d want 1 0 0",
                     got_done, got_err, late);
        end
    endtask

    task automatic test_nack_abort;
        clear_plan();
        nack_plan[2] = 4;
        model_burst(1, 3, 16'h0040, '0);
        drive_burst(1, 3, 16'h0040, '0, 0);
        checks++;
        if (!got_err || got_done || err_code !== 2'd1 || err_idx !== 5'd2) begin
            errors++;
            $display("FAIL abort_status got err%0d done%0d code%0d idx%0d want 1 0 1 2",
                     got_err, got_done, err_code, err_idx);
        end
        checks++;
        if (rd_data !== m_rd) begin
            errors++;
            $display("FAIL abort_data got %h want %h", rd_data, m_rd);
        end
        checks++;
        if (obs_addr.size() !== exp_addr.size() || late !== 0) begin
            errors++;
            $display("FAIL abort_count got %0d late%0d want %0d",
                     obs_addr.size(), late, exp_addr.size());
        end
    endtask

    task automatic test_len_edges;
        logic [127:0] d;
        clear_plan();
        model_burst(0, 0, 16'h0010, '0);
        drive_burst(0, 0, 16'h0010, '0, 0);
        checks++;
        if (!got_done || got_err || obs_addr.size() !== 0 || pulse_cyc !== 2) begin
            errors++;
            $display("FAIL len0 got done%0d err%0d req%0d cyc%0d want 1 0 0 2",
                     got_done, got_err, obs_addr.size(), pulse_cyc);
        end
        model_burst(1, MB + 1, 16'h0010, '0);
        drive_burst(1, MB + 1, 16'h0010, '0, 0);
        checks++;
        if (!got_err || got_done || obs_addr.size() !== 0 ||
            err_code !== 2'd2 || err_idx !== 5'd0) begin
            errors++;
            $display("FAIL len_big got err%0d done%0d req%0d code%0d idx%0d want 1 0 0 2 0",
                     got_err, got_done, obs_addr.size(), err_code, err_idx);
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        model_burst(0, 3, 16'h0200, d);
        drive_burst(0, 3, 16'h0200, d, 1);
        checks++;
        if (obs_addr.size() !== 3 || ready_bad !== 0 || !got_done || !post_ready) begin
            errors++;
            $display("FAIL busy_hold got req%0d rdy%0d done%0d post%0d want 3 0 1 1",
                     obs_addr.size(), ready_bad, got_done, post_ready);
        end
        checks++;
        if (rd_data !== m_rd) begin
            errors++;
            $display("FAIL wr_keeps_rd got %h want %h", rd_data, m_rd);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int bad;
        logic [127:0] d;
        @(negedge clk50M);
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_len   = 5'd4;
        cmd_addr  = 16'h0100;
        cmd_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk50M);
        cmd_valid = 1'b0;
        n = 0;
        while (!(wr_req || rd_req) && n < 20) begin
            @(negedge clk50M);
            n++;
        end
        checks++;
        if (!wr_req) begin
            errors++;
            $display("FAIL rm_start got wr_req %b want 1", wr_req);
        end
        @(negedge clk50M);
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || {wr_req, rd_req, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL rm_ctrl got rdy%b pulses%b want 1 0000",
                     cmd_ready, {wr_req, rd_req, done, err});
        end
        checks++;
        if (rd_data !== '0 || reg_addr !== '0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL rm_data got %h/%h/%0d want 0", rd_data, reg_addr, err_code);
        end
        m_rd = '0;
        @(negedge clk50M);
        rst = 1'b0;
        @(negedge clk50M);
        rw_done = 1'b1;
        ack     = 1'b0;
        @(negedge clk50M);
        rw_done = 1'b0;
        bad = 0;
        repeat (5) begin
            if (wr_req || rd_req || done || err || !cmd_ready) bad++;
            @(negedge clk50M);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rm_stale got %0d activity cycles want 0", bad);
        end
        clear_plan();
        d = {$urandom, $urandom, $urandom, $urandom};
        model_burst(0, 2, 16'h0300, d);
        drive_burst(0, 2, 16'h0300, d, 0);
        checks++;
        if (obs_addr.size() !== 2 || !got_done || obs_addr[0] !== 16'h0300 ||
            obs_byte[0] !== exp_byte[0]) begin
            errors++;
            $display("FAIL rm_next got req%0d done%0d want 2 1", obs_addr.size(), got_done);
        end
    endtask

    task automatic test_random;
        bit rd;
        int len;
        logic [15:0] a;
        logic [127:0] d;
        for (int k = 0; k < 8; k++) begin
            clear_plan();
            for (int i = 0; i < MB; i++) begin
                nack_plan[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
            end
            rd  = 1'($urandom);
            len = ($urandom_range(0, 9) == 0) ? MB + 1 : $urandom_range(0, MB);
            a   = 16'($urandom);
            d   = {$urandom, $urandom, $urandom, $urandom};
            model_burst(rd, len, a, d);
            drive_burst(rd, len, a, d, 0);
            checks++;
            if (obs_addr.size() !== exp_addr.size() || timeout) begin
                errors++;
                $display("FAIL rnd%0d_count got %0d want %0d", k,
                         obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] ||
                    (!rd && obs_byte[i] !== exp_byte[i])) begin
                    errors++;
                    $display("FAIL rnd%0d_req%0d got %h:%h want %h:%h", k, i,
                             obs_addr[i], obs_byte[i], exp_addr[i], exp_byte[i]);
                end
            end
            checks++;
            if (got_done !== exp_done || got_err !== exp_err ||
                err_code !== m_code || err_idx !== 5'(m_idx)) begin
                errors++;
                $display("FAIL rnd%0d_status got %0d%0d c%0d i%0d want %0d%0d c%0d i%0d",
                         k, got_done, got_err, err_code, err_idx,
                         exp_done, exp_err, m_code, m_idx);
            end
            checks++;
            if (rd_data !== m_rd || late !== 0 || extra !== 0 || wrong_dir !== 0) begin
                errors++;
                $display("FAIL rnd%0d_data got %h late%0d extra%0d dir%0d want %h",
                         k, rd_data, late, extra, wrong_dir, m_rd);
            end
        end
        checks++;
        if (both_hi !== 0) begin
            errors++;
            $display("FAIL both_req got %0d want 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_full();
        test_retry();
        test_nack_abort();
        test_reset_mid();
        test_len_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
